// File: rtl/cnt_pkg.sv
// Shared definitions for the alarm-clock time-base counters: clock moduli,
// the per-edge operation type and a generic wrapped next-value helper.
package cnt_pkg;

   localparam int unsigned SEC_LO_MOD = 10;
   localparam int unsigned SEC_HI_MOD = 6;
   localparam int unsigned HR_MOD     = 24;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_COUNT,
      OP_LOAD,
      OP_LD_REJ,
      OP_CLEAR
   } cnt_op_e;

   // Wrapped successor/predecessor for counters that keep their own register.
   function automatic logic [31:0] next_mod(input logic [31:0] cnt,
                                            input logic        up,
                                            input logic [31:0] modulus);
      if (up)
         return (cnt >= modulus - 32'd1) ? '0 : cnt + 32'd1;
      else
         return (cnt == '0) ? modulus - 32'd1 : cnt - 32'd1;
   endfunction

endpackage

// File: rtl/mod_n_counter_next.sv
// Combinational next-value and terminal-detect logic for a modulo-N digit;
// arithmetic is carried one bit wider than the count.
module mod_n_next
   import cnt_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic [WIDTH-1:0] i_cnt,
   input  logic             i_up,
   output logic [WIDTH-1:0] o_nxt,
   output logic             o_term
);

   localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0] MAX_W = MOD_W - (WIDTH+1)'(1);

   logic [WIDTH:0] w_cnt_w;
   logic [WIDTH:0] w_inc;
   logic [WIDTH:0] w_dec;

   assign w_cnt_w = {1'b0, i_cnt};
   assign w_inc   = w_cnt_w + (WIDTH+1)'(1);
   assign w_dec   = w_cnt_w - (WIDTH+1)'(1);

   // The wide compare makes the 2**WIDTH modulus wrap identical to overflow.
   always_comb begin
      o_nxt  = '0;
      o_term = 1'b0;
      if (i_up) begin
         o_nxt  = (w_inc >= MOD_W) ? '0 : w_inc[WIDTH-1:0];
         o_term = (w_cnt_w == MAX_W);
      end else begin
         o_nxt  = w_dec[WIDTH] ? MAX_W[WIDTH-1:0] : w_dec[WIDTH-1:0];
         o_term = (i_cnt == '0);
      end
   end

endmodule

// File: rtl/mod_n_counter.sv
// Registered modulo-N counter digit with clear/load/enable and cascade carry.
// Define MODN_DOWN_EN to add the dn port and down counting.
module mod_n_counter
   import cnt_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
`ifdef MODN_DOWN_EN
   input  logic             dn,
`endif
   output logic [WIDTH-1:0] cnt,
   output logic             term,
   output logic             co,
   output logic             ld_err
);

   localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);

   if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH) || RST_VAL >= MODULUS) begin : g_param_chk
      $error("mod_n_counter: illegal WIDTH/MODULUS/RST_VAL combination");
   end

   logic [WIDTH-1:0] r_cnt;
   logic             r_ld_err;
   logic [WIDTH-1:0] w_nxt;
   logic             w_term;
   logic             w_up;
   logic             w_ld_ok;
   cnt_op_e          w_op;

`ifdef MODN_DOWN_EN
   assign w_up = ~dn;
`else
   assign w_up = 1'b1;
`endif

   mod_n_next #(
      .WIDTH  (WIDTH),
      .MODULUS(MODULUS)
   ) u_next (
      .i_cnt (r_cnt),
      .i_up  (w_up),
      .o_nxt (w_nxt),
      .o_term(w_term)
   );

   assign w_ld_ok = ({1'b0, ld_val} < MOD_W);

   always_comb begin
      w_op = OP_HOLD;
      if (clr)
         w_op = OP_CLEAR;
      else if (ld)
         w_op = w_ld_ok ? OP_LOAD : OP_LD_REJ;
      else if (en)
         w_op = OP_COUNT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= WIDTH'(RST_VAL);
         r_ld_err <= 1'b0;
      end else begin
         r_ld_err <= (w_op == OP_LD_REJ);
         case (w_op)
            OP_CLEAR: r_cnt <= '0;
            OP_LOAD:  r_cnt <= ld_val;
            OP_COUNT: r_cnt <= w_nxt;
            default:  r_cnt <= r_cnt;
         endcase
      end
   end

   assign cnt    = r_cnt;
   assign ld_err = r_ld_err;
   assign term   = w_term;
   // Carry is suppressed on clear/load edges so a chained digit never steps then.
   assign co     = en & w_term & ~clr & ~ld;

endmodule

// File: tb/tb_mod_n_counter.sv
// Self-checking bench for mod_n_counter: directed steps plus random cycles
// against a modular-arithmetic reference model.
module tb_mod_n_counter;

`ifdef MODN_DOWN_EN
   localparam bit DOWN_EN = 1'b1;
`else
   localparam bit DOWN_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       a_en = 1'b0, a_clr = 1'b0, a_ld = 1'b0, a_dn = 1'b0;
   logic [3:0] a_ldv = '0;
   logic       b_en = 1'b0, c_en = 1'b0, k_en = 1'b0;
   logic       zero = 1'b0;
   logic [2:0] zero3 = '0;
   logic [3:0] zero4 = '0;

   logic [3:0] a_cnt;  logic a_term, a_co, a_err;
   logic [2:0] b_cnt;  logic b_term, b_co, b_err;
   logic [3:0] c_cnt;  logic c_term, c_co, c_err;
   logic [3:0] lo_cnt; logic lo_term, lo_co, lo_err;
   logic [2:0] hi_cnt; logic hi_term, hi_co, hi_err;

   int nvec = 0;
   int nerr = 0;
   int ma, ma_err, mb, mc, tot;

   mod_n_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_a (
      .clk(clk), .rst_n(rst_n), .en(a_en), .clr(a_clr), .ld(a_ld), .ld_val(a_ldv),
`ifdef MODN_DOWN_EN
      .dn(a_dn),
`endif
      .cnt(a_cnt), .term(a_term), .co(a_co), .ld_err(a_err));

   mod_n_counter #(.WIDTH(3), .MODULUS(6), .RST_VAL(0)) u_b (
      .clk(clk), .rst_n(rst_n), .en(b_en), .clr(zero), .ld(zero), .ld_val(zero3),
`ifdef MODN_DOWN_EN
      .dn(zero),
`endif
      .cnt(b_cnt), .term(b_term), .co(b_co), .ld_err(b_err));

   mod_n_counter #(.WIDTH(4), .MODULUS(16), .RST_VAL(3)) u_c (
      .clk(clk), .rst_n(rst_n), .en(c_en), .clr(zero), .ld(zero), .ld_val(zero4),
`ifdef MODN_DOWN_EN
      .dn(zero),
`endif
      .cnt(c_cnt), .term(c_term), .co(c_co), .ld_err(c_err));

   mod_n_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_lo (
      .clk(clk), .rst_n(rst_n), .en(k_en), .clr(zero), .ld(zero), .ld_val(zero4),
`ifdef MODN_DOWN_EN
      .dn(zero),
`endif
      .cnt(lo_cnt), .term(lo_term), .co(lo_co), .ld_err(lo_err));

   mod_n_counter #(.WIDTH(3), .MODULUS(6), .RST_VAL(0)) u_hi (
      .clk(clk), .rst_n(rst_n), .en(lo_co), .clr(zero), .ld(zero), .ld_val(zero3),
`ifdef MODN_DOWN_EN
      .dn(zero),
`endif
      .cnt(hi_cnt), .term(hi_term), .co(hi_co), .ld_err(hi_err));

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      a_en = 1'b0; a_clr = 1'b0; a_ld = 1'b0;
      b_en = 1'b0; c_en = 1'b0; k_en = 1'b0;
      rst_n = 1'b0;
      #2;
      ma = 0; ma_err = 0; mb = 0; mc = 3; tot = 0;
      chk("rst_a_cnt", a_cnt, ma);
      chk("rst_a_lderr", a_err, 0);
      chk("rst_b_cnt", b_cnt, mb);
      chk("rst_c_cnt", c_cnt, mc);
      chk("rst_lo_cnt", lo_cnt, 0);
      chk("rst_hi_cnt", hi_cnt, 0);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic cycle(input logic en, input logic clr, input logic ld,
                        input logic [3:0] ldv, input logic dn,
                        input logic ben, input logic cen, input logic ken);
      bit down;
      bit t;
      a_en = en; a_clr = clr; a_ld = ld; a_ldv = ldv; a_dn = dn;
      b_en = ben; c_en = cen; k_en = ken;
      down = DOWN_EN && dn;
      #1;
      t = down ? (ma == 0) : (ma == 9);
      chk("a_term", a_term, t);
      chk("a_co", a_co, en && t && !clr && !ld);
      chk("b_term", b_term, mb == 5);
      chk("c_term", c_term, mc == 15);
      chk("lo_co", lo_co, ken && (tot % 10 == 9));
      @(posedge clk);
      #1;
      ma_err = 0;
      if (clr) ma = 0;
      else if (ld) begin
         if (ldv < 10) ma = int'(ldv);
         else ma_err = 1;
      end else if (en) ma = down ? (ma + 9) % 10 : (ma + 1) % 10;
      if (ben) mb = (mb + 1) % 6;
      if (cen) mc = (mc + 1) % 16;
      if (ken) tot = (tot + 1) % 60;
      chk("a_cnt", a_cnt, ma);
      chk("a_lderr", a_err, ma_err);
      chk("b_cnt", b_cnt, mb);
      chk("c_cnt", c_cnt, mc);
      chk("lo_cnt", lo_cnt, tot % 10);
      chk("hi_cnt", hi_cnt, tot / 10);
   endtask

   initial begin
      ma = 0; ma_err = 0; mb = 0; mc = 3; tot = 0;
      @(posedge clk);
      #1;
      do_reset();

      repeat (7) cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("a_mid_cnt", a_cnt, 7);
      do_reset();
      repeat (12) cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      cycle(1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      cycle(1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (60) cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);

      cycle(1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (300)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
